pipelined_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 18 +
 rtl/pipelined_shifter_if.sv | 42 ++++
 rtl/shift_stage.sv | 75 +++++++
 rtl/pipelined_shifter.sv | 93 +++++++++
 tb/tb_pipelined_shifter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined barrel shifter: the width of the shift
// mode field and the encodings of the four shift modes.
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam int OP_W = 2;

    // Shift modes as seen on in_op
    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/pipelined_shifter_if.sv
// -----------------------------------------------------------------------------
// pipelined_shifter_if
// Bundles the operand-side and result-side valid/ready handshakes of the
// pipelined shifter.
//   master : drives operations in and consumes results (execute stage side)
//   slave  : the shifter itself
// Signals:
//   in_valid/in_ready, in_data, in_shamt, in_op, in_tag  - operation channel
//   out_valid/out_ready, out_data, out_tag               - result channel
// -----------------------------------------------------------------------------
interface pipelined_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [OP_W-1:0]    in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One registered stage of the pipelined barrel shifter. It shifts its upstream
// operand by the fixed distance DIST when the matching shift-amount bit is
// set, and otherwise passes the operand through.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   up_valid .. up_tag  - operation fields from the previous stage (or input)
//   ready               - this stage may load this cycle (from the ready chain)
//   valid .. tag        - registered fields handed to the next stage
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int DIST    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               up_valid,
    input  logic [WIDTH-1:0]   up_data,
    input  logic [SHAMT_W-1:0] up_shamt,
    input  logic [OP_W-1:0]    up_op,
    input  logic [TAG_W-1:0]   up_tag,
    input  logic               ready,
    output logic               valid,
    output logic [WIDTH-1:0]   data,
    output logic [SHAMT_W-1:0] shamt,
    output logic [OP_W-1:0]    op,
    output logic [TAG_W-1:0]   tag
);

    // Shift-amount bit that enables this stage's fixed distance
    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] shifted;

    // Mode mux for the fixed distance. SRA fills from this stage's input MSB,
    // which still carries the original sign because earlier stages did the same.
    always_comb begin
        shifted = up_data;
        if (up_shamt[BIT]) begin
            case (up_op)
                OP_SLL:  shifted = up_data << DIST;
                OP_SRL:  shifted = up_data >> DIST;
                OP_SRA:  shifted = $signed(up_data) >>> DIST;
                OP_ROR:  shifted = {up_data[DIST-1:0], up_data[WIDTH-1:DIST]};
                default: shifted = up_data;
            endcase
        end
    end

    // Stage registers: load when ready, otherwise hold. Payload fields only
    // move with a valid operation so idle input values never disturb state.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            op    <= '0;
            tag   <= '0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data  <= shifted;
                shamt <= up_shamt;
                op    <= up_op;
                tag   <= up_tag;
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
// Fully pipelined barrel shifter (SLL/SRL/SRA/ROR) with one registered stage
// per shift-amount bit; stage 0 shifts by the largest power of two and the
// last stage by one. Sustains one operation per cycle with valid/ready
// backpressure and carries a sideband tag with each operation.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset, discards everything in flight
//   bus   - pipelined_shifter_if slave: operation and result channels
// -----------------------------------------------------------------------------
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    pipelined_shifter_if.slave   bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int S       = SHAMT_W;

    logic               valid_q [S];
    logic [WIDTH-1:0]   data_q  [S];
    logic [SHAMT_W-1:0] shamt_q [S];
    logic [OP_W-1:0]    op_q    [S];
    logic [TAG_W-1:0]   tag_q   [S];
    logic [S:0]         stage_ready;

    // Combinational ready chain from the consumer back to the input: a stage
    // can load if it is empty or its contents move on this same cycle.
    always_comb begin
        stage_ready[S] = bus.out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            stage_ready[k] = !valid_q[k] || stage_ready[k+1];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_first
            shift_stage #(
                .WIDTH   (WIDTH),
                .TAG_W   (TAG_W),
                .SHAMT_W (SHAMT_W),
                .DIST    (1 << (S - 1))
            ) u_stage (
                .clock    (clock),
                .reset    (reset),
                .up_valid (bus.in_valid),
                .up_data  (bus.in_data),
                .up_shamt (bus.in_shamt),
                .up_op    (bus.in_op),
                .up_tag   (bus.in_tag),
                .ready    (stage_ready[0]),
                .valid    (valid_q[0]),
                .data     (data_q[0]),
                .shamt    (shamt_q[0]),
                .op       (op_q[0]),
                .tag      (tag_q[0])
            );
        end else begin : g_next
            shift_stage #(
                .WIDTH   (WIDTH),
                .TAG_W   (TAG_W),
                .SHAMT_W (SHAMT_W),
                .DIST    (1 << (S - 1 - k))
            ) u_stage (
                .clock    (clock),
                .reset    (reset),
                .up_valid (valid_q[k-1]),
                .up_data  (data_q[k-1]),
                .up_shamt (shamt_q[k-1]),
                .up_op    (op_q[k-1]),
                .up_tag   (tag_q[k-1]),
                .ready    (stage_ready[k]),
                .valid    (valid_q[k]),
                .data     (data_q[k]),
                .shamt    (shamt_q[k]),
                .op       (op_q[k]),
                .tag      (tag_q[k])
            );
        end
    end

    assign bus.in_ready  = stage_ready[0];
    assign bus.out_valid = valid_q[S-1];
    assign bus.out_data  = data_q[S-1];
    assign bus.out_tag   = tag_q[S-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_shifter
// Directed bench for pipelined_shifter: a WIDTH=32 instance for the main
// scenarios and a WIDTH=8, TAG_W=2 instance for the parameter sweep.
// -----------------------------------------------------------------------------
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clock = ~clock;

    // Cycle index, advanced on each rising edge
    always @(posedge clock) cyc <= cyc + 1;

    pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) bus  ();
    pipelined_shifter_if #(.WIDTH(8),  .TAG_W(2)) bus8 ();

    pipelined_shifter #(.WIDTH(32), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pipelined_shifter #(.WIDTH(8), .TAG_W(2)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    // Transfer log of the 32-bit instance, sampled mid-cycle
    logic [31:0] got_data   [$];
    logic [4:0]  got_tag    [$];
    int          got_cyc    [$];
    int          in_cyc     [$];
    logic [31:0] stall_data [$];
    logic [4:0]  stall_tag  [$];
    int          stall_in;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_tag.push_back(bus.out_tag);
                got_cyc.push_back(cyc);
            end
            if (bus.out_valid && !bus.out_ready) begin
                stall_data.push_back(bus.out_data);
                stall_tag.push_back(bus.out_tag);
            end
            if (bus.in_valid && bus.in_ready) in_cyc.push_back(cyc);
            if (bus.in_valid && !bus.in_ready) stall_in++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        got_data.delete();
        got_tag.delete();
        got_cyc.delete();
        in_cyc.delete();
        stall_data.delete();
        stall_tag.delete();
        stall_in = 0;
    endtask

    // Idle input with junk payload that must not affect anything
    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_shamt = 5'($urandom);
        bus.in_op    = 2'($urandom);
        bus.in_tag   = 5'($urandom);
    endtask

    // Present one operation and hold it until accepted (bounded)
    task automatic drive_op(input logic [31:0] d, input logic [4:0] sh,
                            input logic [1:0] op, input logic [4:0] tg);
        bit done  = 1'b0;
        int tries = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_op    = op;
        bus.in_tag   = tg;
        while (!done && tries < 50) begin
            @(negedge clock);
            done = bus.in_ready;
            step();
            tries++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL drive_timeout: in_ready never rose for tag %0d", tg);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_ready  = 1'b1;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_shamt  = '0;
        bus8.in_op     = '0;
        bus8.in_tag    = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_shamt = 5'd3;
        bus.in_op    = OP_SLL;
        bus.in_tag   = 5'd17;
        repeat (3) step();
        reset = 1'b0;
        idle_in();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_out_data: got %h expected 00000000", bus.out_data);
        end
        checks++;
        if (bus.out_tag !== 5'h0) begin
            failures++;
            $display("[TB] FAIL reset_out_tag: got %h expected 00", bus.out_tag);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid_w8: got %b expected 0", bus8.out_valid);
        end
        clear_log();
        repeat (10) step();
        checks++;
        if (got_data.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_input_dropped: got %0d results expected 0", got_data.size());
        end
    endtask

    task automatic test_modes();
        logic [31:0] vin  [4] = '{32'h0000_0001, 32'hF000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [4:0]  vsh  [4] = '{5'd31, 5'd28, 5'd4, 5'd8};
        logic [1:0]  vop  [4] = '{OP_SLL, OP_SRL, OP_SRA, OP_ROR};
        logic [31:0] vexp [4] = '{32'h8000_0000, 32'h0000_000F, 32'hF800_0000, 32'h7812_3456};
        for (int i = 0; i < 4; i++) begin
            clear_log();
            drive_op(vin[i], vsh[i], vop[i], 5'(10 + i));
            idle_in();
            repeat (8) step();
            checks++;
            if (got_data.size() != 1 || in_cyc.size() != 1) begin
                failures++;
                $display("[TB] FAIL mode%0d_count: got %0d results expected 1", i, got_data.size());
            end else begin
                checks++;
                if (got_data[0] !== vexp[i]) begin
                    failures++;
                    $display("[TB] FAIL mode%0d_data: got %h expected %h", i, got_data[0], vexp[i]);
                end
                checks++;
                if (got_tag[0] !== 5'(10 + i)) begin
                    failures++;
                    $display("[TB] FAIL mode%0d_tag: got %0d expected %0d", i, got_tag[0], 10 + i);
                end
                checks++;
                if (got_cyc[0] - in_cyc[0] != 5) begin
                    failures++;
                    $display("[TB] FAIL mode%0d_latency: got %0d expected 5", i, got_cyc[0] - in_cyc[0]);
                end
            end
        end
    endtask

    task automatic test_zero_shift();
        clear_log();
        for (int i = 0; i < 4; i++) drive_op(32'hDEAD_BEEF, 5'd0, 2'(i), 5'(i + 1));
        idle_in();
        repeat (10) step();
        checks++;
        if (got_data.size() != 4) begin
            failures++;
            $display("[TB] FAIL zero_count: got %0d expected 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== 32'hDEAD_BEEF || got_tag[i] !== 5'(i + 1)) begin
                    failures++;
                    $display("[TB] FAIL zero%0d: got %h/%0d expected deadbeef/%0d",
                             i, got_data[i], got_tag[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        for (int i = 0; i < 8; i++) drive_op(32'h1, 5'(i), OP_SLL, 5'(i));
        idle_in();
        repeat (12) step();
        checks++;
        if (stall_in != 0) begin
            failures++;
            $display("[TB] FAIL stream_in_ready: got %0d stalled cycles expected 0", stall_in);
        end
        checks++;
        if (got_data.size() != 8 || in_cyc.size() != 8) begin
            failures++;
            $display("[TB] FAIL stream_count: got %0d expected 8", got_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_data[i] !== (32'h1 << i) || got_tag[i] !== 5'(i)
                    || got_cyc[i] != in_cyc[0] + 5 + i) begin
                    failures++;
                    $display("[TB] FAIL stream%0d: got %h/%0d at +%0d expected %h/%0d at +%0d",
                             i, got_data[i], got_tag[i], got_cyc[i] - in_cyc[0],
                             32'h1 << i, i, 5 + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        fork
            begin
                for (int i = 0; i < 8; i++) drive_op(32'h1, 5'(i), OP_SLL, 5'(i));
                idle_in();
            end
            begin
                repeat (6) step();
                bus.out_ready = 1'b0;
                repeat (3) step();
                bus.out_ready = 1'b1;
            end
        join
        repeat (15) step();
        checks++;
        if (stall_in == 0) begin
            failures++;
            $display("[TB] FAIL bp_in_ready: got 0 stalled input cycles expected >0");
        end
        checks++;
        if (stall_data.size() != 3) begin
            failures++;
            $display("[TB] FAIL bp_stall_cycles: got %0d expected 3", stall_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (stall_data[i] !== 32'h2 || stall_tag[i] !== 5'd1) begin
                    failures++;
                    $display("[TB] FAIL bp_frozen%0d: got %h/%0d expected 00000002/1",
                             i, stall_data[i], stall_tag[i]);
                end
            end
        end
        checks++;
        if (got_data.size() != 8) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d expected 8", got_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_data[i] !== (32'h1 << i) || got_tag[i] !== 5'(i)) begin
                    failures++;
                    $display("[TB] FAIL bp_order%0d: got %h/%0d expected %h/%0d",
                             i, got_data[i], got_tag[i], 32'h1 << i, i);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        clear_log();
        for (int i = 0; i < 3; i++) drive_op(32'h0000_00FF, 5'(4 * i), OP_SLL, 5'(20 + i));
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_shamt = 5'd0;
        bus.in_op    = OP_SLL;
        bus.in_tag   = 5'd7;
        step();
        reset = 1'b0;
        idle_in();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_valid: got %b expected 0", bus.out_valid);
        end
        clear_log();
        repeat (10) step();
        checks++;
        if (got_data.size() != 0) begin
            failures++;
            $display("[TB] FAIL mid_reset_flush: got %0d results expected 0", got_data.size());
        end
        clear_log();
        drive_op(32'h1234_5678, 5'd8, OP_ROR, 5'd9);
        idle_in();
        repeat (8) step();
        checks++;
        if (got_data.size() != 1 || in_cyc.size() != 1) begin
            failures++;
            $display("[TB] FAIL mid_reset_new_count: got %0d expected 1", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 32'h7812_3456 || got_tag[0] !== 5'd9
                || got_cyc[0] - in_cyc[0] != 5) begin
                failures++;
                $display("[TB] FAIL mid_reset_new: got %h/%0d lat %0d expected 78123456/9 lat 5",
                         got_data[0], got_tag[0], got_cyc[0] - in_cyc[0]);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] vin  [2] = '{8'h81, 8'h80};
        logic [2:0] vsh  [2] = '{3'd1, 3'd7};
        logic [1:0] vop  [2] = '{OP_ROR, OP_SRA};
        logic [7:0] vexp [2] = '{8'hC0, 8'hFF};
        for (int i = 0; i < 2; i++) begin
            int   c_in;
            int   c_out = -1;
            logic rdy;
            logic [7:0] d_out = '0;
            logic [1:0] t_out = '0;
            bus8.in_valid = 1'b1;
            bus8.in_data  = vin[i];
            bus8.in_shamt = vsh[i];
            bus8.in_op    = vop[i];
            bus8.in_tag   = 2'(i + 1);
            @(negedge clock);
            c_in = cyc;
            rdy  = bus8.in_ready;
            step();
            bus8.in_valid = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clock);
                if (bus8.out_valid) begin
                    c_out = cyc;
                    d_out = bus8.out_data;
                    t_out = bus8.out_tag;
                    break;
                end
            end
            step();
            checks++;
            if (rdy !== 1'b1 || c_out < 0) begin
                failures++;
                $display("[TB] FAIL w8_%0d_handshake: in_ready %b, result seen %0d expected 1/1",
                         i, rdy, c_out >= 0);
            end else begin
                checks++;
                if (d_out !== vexp[i] || t_out !== 2'(i + 1)) begin
                    failures++;
                    $display("[TB] FAIL w8_%0d_data: got %h/%0d expected %h/%0d",
                             i, d_out, t_out, vexp[i], i + 1);
                end
                checks++;
                if (c_out - c_in != 3) begin
                    failures++;
                    $display("[TB] FAIL w8_%0d_latency: got %0d expected 3", i, c_out - c_in);
                end
            end
        end
    endtask

    initial begin
        stall_in = 0;
        test_reset();
        test_modes();
        test_zero_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
